mul_seq_16: RTL and testbench



---
 rtl/mul_seq_16_if.sv | 35 +++
 rtl/mul_seq_16.sv | 117 +++++++++++
 tb/tb_mul_seq_16.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_seq_16_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_16_if
// Description : Operand/result handshakes plus the external adder operand
//               and sum lines for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             busy;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] add_sum;

    // Environment side: operand source, result sink and the adder.
    modport master (
        output in_valid, a, b, out_ready, add_sum,
        input  in_ready, out_valid, product, busy, add_x, add_y
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready, add_sum,
        output in_ready, out_valid, product, busy, add_x, add_y
    );
endinterface
`default_nettype wire

// File: rtl/mul_seq_16.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_16
// Description : Shift-and-add multiplier using an external 16-bit adder;
//               returns (a*b) mod 2^WIDTH after a fixed WIDTH-cycle run.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_16 #(
    parameter int WIDTH = 16
) (
    input  wire          clk,
    input  wire          rst,
    mul_seq_16_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_add_x     = '0;
        w_add_y     = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_add_x = r_acc;
                w_add_y = r_mplier[0] ? r_mcand : '0;
                if (r_cnt == c_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= bus.a;
                        r_mplier <= bus.b;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // Always WIDTH iterations, even once the multiplier is exhausted.
                    r_acc    <= bus.add_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_acc;
    assign bus.add_x     = w_add_x;
    assign bus.add_y     = w_add_y;
endmodule
`default_nettype wire

// File: tb/tb_mul_seq_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_16
// Description : Directed and random scoreboard bench for mul_seq_16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_16;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    mul_seq_16_if #(.WIDTH(WIDTH)) bus ();

    // Behavioural stand-in for the downstream combinational adder.
    assign bus.add_sum = bus.add_x + bus.add_y;

    mul_seq_16 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] full;
        full = {16'h0, x} * {16'h0, y};
        return full[15:0];
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit chk_zero_y);
        int          cyc;
        bit          y_ok;
        bit          stable;
        logic [15:0] exp;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        cyc  = 1;
        y_ok = 1'b1;
        while (!bus.out_valid && cyc < 40) begin
            if (bus.add_y !== 16'h0) y_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency_to_out_valid", 32'(cyc), 32'd17);
        if (chk_zero_y) check("add_y_zero_in_run", 32'(y_ok), 32'd1);
        check("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (bus.out_valid !== 1'b1 || bus.product !== exp) stable = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) check("held_under_backpressure", 32'(stable), 32'd1);
        bus.out_ready = 1'b1;
        check("product", 32'(bus.product), 32'(exp));
        check("out_valid_at_handshake", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
        check("out_valid_single_pulse", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int got;
        int acc_n;
        int last_acc;
        bit gap_ok;
        bit no_valid;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_product",   32'(bus.product),   32'd0);
        check("rst_add_x",     32'(bus.add_x),     32'd0);
        check("rst_add_y",     32'(bus.add_y),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'd3, 16'd5, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        do_op(16'h1234, 16'h0000, 0, 1'b1);
        do_op(16'h00FF, 16'h0101, 10, 1'b0);

        // Reset in the middle of a run discards the result.
        bus.a        = 16'd9;
        bus.b        = 16'd11;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy",     32'(bus.busy),      32'd0);
        check("midrun_rst_in_ready", 32'(bus.in_ready),  32'd1);
        check("midrun_rst_acc",      32'(bus.product),   32'd0);
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        no_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) no_valid = 1'b0;
        end
        check("midrun_no_out_valid", 32'(no_valid), 32'd1);
        do_op(16'd7, 16'd6, 0, 1'b0);

        // in_valid held high with fresh operands every cycle.
        bus.out_ready = 1'b1;
        got      = 0;
        acc_n    = 0;
        last_acc = -1;
        gap_ok   = 1'b1;
        cyc      = 0;
        while (got < 20 && cyc < 20 * 18 + 60) begin
            if (bus.out_valid) begin
                if (sb.size() > 0) check("rand_product", 32'(bus.product), 32'(sb.pop_front()));
                else check("rand_unexpected_output", 32'd1, 32'd0);
                got++;
            end
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.in_valid = (acc_n < 20);
            if (bus.in_ready && acc_n < 20) begin
                if (last_acc >= 0 && (cyc - last_acc) != 18) gap_ok = 1'b0;
                last_acc = cyc;
                sb.push_back(model(bus.a, bus.b));
                acc_n++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("rand_result_count", 32'(got), 32'd20);
        check("rand_accept_spacing", 32'(gap_ok), 32'd1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
